// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the core's load/store interface. Accepts one word
//   request at a time, waits WAIT_CYCLES cycles, then performs the RAM
//   access and presents the result until the requester takes it.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  request present            req_ready  responder can accept
//   req_write  1 = store, 0 = load        req_addr   byte address
//   req_wdata  store data                 req_be     store byte enables
//   rsp_valid  response present           rsp_ready  requester takes response
//   rsp_rdata  load data (0 for stores/errors)
//   rsp_err    misaligned or out-of-range request
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        armed;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          handshake;
    logic          finish;
    logic          addr_err;
    logic          do_write;
    logic [AW-1:0] idx;
    logic [31:0]   merged;

    // armed holds req_ready low until the first edge after reset release
    assign req_ready = armed && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign handshake = rsp_valid && rsp_ready;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign addr_err = (lat_addr[1:0] != 2'b00)
                   || ({1'b0, lat_addr} < {1'b0, BASE_ADDR})
                   || ({1'b0, lat_addr} >= LIMIT);

    // Word index of (addr - BASE_ADDR); only the low index bits matter
    assign idx = lat_addr[AW+1:2] - BASE_ADDR[AW+1:2];

    always_comb begin
        merged = mem[idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (lat_be[i]) begin
                merged[8*i +: 8] = lat_wdata[8*i +: 8];
            end
        end
    end

    // The accept edge always lands in WAIT so that the response appears
    // WAIT_CYCLES+1 edges after acceptance, including when WAIT_CYCLES is 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (cnt == 4'(WAIT_CYCLES)) begin
                    state_next = RESP;
                    finish     = 1'b1;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        do_write = finish && lat_write && !addr_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            armed     <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            armed <= 1'b1;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (finish) begin
                err_q   <= addr_err;
                rdata_q <= (!addr_err && !lat_write) ? mem[idx] : '0;
            end else if (handshake) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder. Instance 0 uses WAIT_CYCLES=2,
//   instance 1 uses WAIT_CYCLES=0; both use DEPTH_WORDS=256, BASE_ADDR=0.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks   = 0;
    int failures = 0;

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        to;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request on instance d and return once rsp_valid is seen
    // (sampled 1 time unit after each edge); the response is left pending.
    // Request inputs are scrambled right after the accept edge.
    task automatic run_req(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           output int l, output logic [31:0] r,
                           output logic e, output logic t);
        int n;
        t = 1'b0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) t = 1'b1;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_write[d] = ~w;
        req_addr[d]  = ~a;
        req_wdata[d] = ~wd;
        req_be[d]    = ~be;
        l = 0;
        while (rsp_valid[d] !== 1'b1 && l < 40) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (l >= 40) t = 1'b1;
        r = rsp_rdata[d];
        e = rsp_err[d];
    endtask

    task automatic drain;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL reset_req_ready cyc%0d got=%b exp=0", c, req_ready[0]); end
            checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid cyc%0d got=%b exp=0", c, rsp_valid[0]); end
            checks++; if (rsp_rdata[0] !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata cyc%0d got=%h exp=0", c, rsp_rdata[0]); end
            checks++; if (rsp_err[0] !== 1'b0) begin failures++; $display("FAIL reset_rsp_err cyc%0d got=%b exp=0", c, rsp_err[0]); end
        end
        reset = 1'b1;
        #1;
        checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL release_ready_early got=%b exp=0", req_ready[0]); end
        @(posedge clk);
        #1;
        checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL release_ready0 got=%b exp=1", req_ready[0]); end
        checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL release_ready1 got=%b exp=1", req_ready[1]); end
        checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL release_rsp_valid got=%b exp=0", rsp_valid[0]); end
    endtask

    task automatic test_store_load;
        run_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL st_timeout got=%b exp=0", to); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL st_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL st_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL st_rdata got=%h exp=0", rd); end
        drain();
        checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL st_clear_valid got=%b exp=0", rsp_valid[0]); end
        checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL st_idle_ready got=%b exp=1", req_ready[0]); end
        run_req(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, to);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld_err got=%b exp=0", er); end
        drain();
        checks++; if (rsp_rdata[0] !== 32'h0) begin failures++; $display("FAIL ld_clear_rdata got=%h exp=0", rsp_rdata[0]); end
    endtask

    task automatic test_partial_store;
        run_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er, to);
        drain();
        run_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er, to);
        drain();
        run_req(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, to);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL partial_rdata got=%h exp=11bb33dd", rd); end
        drain();
        // zero byte-enable store: acknowledged, RAM untouched
        run_req(0, 1'b1, 32'h10, 32'h12345678, 4'h0, lat, rd, er, to);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL be0_err got=%b exp=0", er); end
        drain();
        run_req(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er, to);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL be0_unchanged got=%h exp=deadbeef", rd); end
        drain();
    endtask

    task automatic test_errors;
        run_req(0, 1'b1, 32'h0, 32'h01020304, 4'hF, lat, rd, er, to);
        drain();
        run_req(0, 1'b0, 32'h12, 32'h0, 4'hF, lat, rd, er, to);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
        drain();
        checks++; if (rsp_err[0] !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", rsp_err[0]); end
        run_req(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, lat, rd, er, to);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_err got=%b exp=1", er); end
        drain();
        run_req(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er, to);
        checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL range_nowrite got=%h exp=01020304", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL word0_err got=%b exp=0", er); end
        drain();
        run_req(0, 1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, lat, rd, er, to);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL top_word_err got=%b exp=0", er); end
        drain();
        run_req(0, 1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd, er, to);
        checks++; if (rd !== 32'h0BADCAFE) begin failures++; $display("FAIL top_word_rdata got=%h exp=0badcafe", rd); end
        drain();
    endtask

    task automatic test_zero_wait_backpressure;
        logic stable;
        run_req(1, 1'b1, 32'h40, 32'h5A5A1234, 4'hF, lat, rd, er, to);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zw_st_latency got=%0d exp=1", lat); end
        drain();
        rsp_ready[1] = 1'b0;
        run_req(1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL zw_timeout got=%b exp=0", to); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL zw_ld_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 32'h5A5A1234) begin failures++; $display("FAIL zw_rdata got=%h exp=5a5a1234", rd); end
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h5A5A1234 || req_ready[1] !== 1'b0)
                stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b exp=1 (valid=%b rdata=%h ready=%b)", stable, rsp_valid[1], rsp_rdata[1], req_ready[1]); end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid[1]); end
        checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", req_ready[1]); end
        checks++; if (rsp_rdata[1] !== 32'h0) begin failures++; $display("FAIL bp_release_rdata got=%h exp=0", rsp_rdata[1]); end
    endtask

    task automatic test_reset_mid_store;
        logic stray;
        int n;
        run_req(0, 1'b1, 32'h30, 32'h13579BDF, 4'hF, lat, rd, er, to);
        drain();
        @(negedge clk);
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'hCAFEF00D;
        req_be[0]    = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", rsp_valid[0]); end
        checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", req_ready[0]); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0] !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL midrst_stray_valid got=%b exp=0", stray); end
        run_req(0, 1'b0, 32'h30, 32'h0, 4'h0, lat, rd, er, to);
        checks++; if (rd !== 32'h13579BDF) begin failures++; $display("FAIL midrst_old_value got=%h exp=13579bdf", rd); end
        drain();
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
            rsp_ready[d] = 1'b1;
        end
        test_reset();
        test_store_load();
        test_partial_store();
        test_errors();
        test_zero_wait_backpressure();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
